// File: rtl/pulse_seq_scheduler.sv
// rtl/pulse_seq_scheduler.sv - round-robin scheduler for one shared pulse-sequence generator
//
// Ports:
//   clk       rising-edge clock
//   reset_b   synchronous active-low reset
//   req       level requests, one bit per requester
//   grant     one-hot owner of the generator, or all zero
//   grant_id  binary index of the current or last owner
//   x_out     one-cycle start strobe to the generator's x_in
//   busy      high whenever the scheduler is not idle
//   done      one-cycle completion pulse to the owner
module pulse_seq_scheduler #(
  parameter int N_REQ   = 4,
  parameter int SEQ_LEN = 6,
  parameter int GAP     = 1
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       x_out,
  output logic                       busy,
  output logic [N_REQ-1:0]           done
);

  localparam int IW      = $clog2(N_REQ);
  localparam int IW1     = IW + 1;
  localparam int CNT_MAX = (SEQ_LEN > GAP) ? SEQ_LEN : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SEQ_LOAD = CW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_GAP
  } state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  winner;
  logic [IW-1:0]  ptr_next;
  logic [IW1-1:0] cand;
  logic           found;

  // Scan req starting at ptr, wrapping modulo N_REQ; first set bit wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + IW1'(i);
      if (cand >= IW1'(N_REQ)) begin
        cand = cand - IW1'(N_REQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        winner = cand[IW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign ptr_next = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);

  // Outputs are assigned for the state being entered, so every output is a
  // flop and matches the state it describes in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant    <= '0;
      grant_id <= '0;
      x_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= '0;
    end else begin
      x_out <= 1'b0;
      done  <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state    <= S_START;
            x_out    <= 1'b1;
            grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            grant_id <= winner;
            busy     <= 1'b1;
            ptr      <= ptr_next;
          end
        end
        S_START: begin
          state <= S_RUN;
          cnt   <= SEQ_LOAD;
          // A one-cycle run completes in its first RUN cycle.
          if (SEQ_LEN == 1) begin
            done <= grant;
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            grant <= '0;
            cnt   <= GAP_LOAD;
            if (GAP > 0) begin
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
            // done lands on the RUN cycle whose counter reads zero.
            if (cnt == CW'(1)) begin
              done <= grant;
            end
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// tb/tb_pulse_seq_scheduler.sv - scoreboard bench for pulse_seq_scheduler
module tb_pulse_seq_scheduler;

  localparam int N_REQ   = 4;
  localparam int SEQ_LEN = 6;

  logic       clk;
  logic       reset_b;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       x_out;
  logic       busy;
  logic [3:0] done;

  logic [3:0] req_g;
  logic [3:0] grant_g;
  logic [1:0] grant_id_g;
  logic       x_out_g;
  logic       busy_g;
  logic [3:0] done_g;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int cy;
    bit is_done;
    int id;
  } ev_t;

  ev_t exp_q[$];

  pulse_seq_scheduler #(.N_REQ(N_REQ), .SEQ_LEN(SEQ_LEN), .GAP(1)) u_dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .x_out    (x_out),
    .busy     (busy),
    .done     (done)
  );

  pulse_seq_scheduler #(.N_REQ(N_REQ), .SEQ_LEN(SEQ_LEN), .GAP(0)) u_gap0 (
    .clk      (clk),
    .reset_b  (reset_b),
    .req      (req_g),
    .grant    (grant_g),
    .grant_id (grant_id_g),
    .x_out    (x_out_g),
    .busy     (busy_g),
    .done     (done_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_ev(input int cy, input bit is_done, input int id);
    ev_t e;
    e.cy = cy;
    e.is_done = is_done;
    e.id = id;
    exp_q.push_back(e);
  endtask

  // A full run requested in IDLE cycle c: strobe at c+1, done at c+SEQ_LEN+1.
  task automatic push_run(input int c, input int id);
    push_ev(c + 1, 1'b0, id);
    push_ev(c + 1 + SEQ_LEN, 1'b1, id);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard: every strobe or done must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (x_out || (done != 4'd0)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_event", 32'({x_out, done}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.cy));
        chk("ev_xout", 32'(x_out), e.is_done ? 32'd0 : 32'd1);
        chk("ev_done", 32'(done), e.is_done ? (32'd1 << e.id) : 32'd0);
        chk("ev_grant", 32'(grant), 32'd1 << e.id);
        chk("ev_grant_id", 32'(grant_id), 32'(e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_b = 1'b0;
    req     = 4'b0000;
    req_g   = 4'b0000;
    repeat (3) @(negedge clk);

    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // All requesting: order 0,1,2,3,0 at 9-cycle spacing.
    reset_b = 1'b1;
    c = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_run(c + 9 * k, k % 4);
    to_cyc(c + 28);
    chk("rr_id3", 32'(grant_id), 32'd3);
    to_cyc(c + 37);
    req = 4'b0000;
    chk("rr_wrap_id0", 32'(grant_id), 32'd0);
    to_cyc(c + 46);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Drop mid-run: requester 2 deasserts in the third RUN cycle.
    c = cyc;
    req = 4'b0100;
    push_run(c, 2);
    to_cyc(c + 4);
    req = 4'b0000;
    chk("drop_busy", 32'(busy), 32'd1);
    to_cyc(c + 8);
    chk("drop_grant_gap", 32'(grant), 32'd0);
    to_cyc(c + 9);
    chk("drop_idle_busy", 32'(busy), 32'd0);

    // Pointer fairness after serving 2: 3 first, then 0.
    c = cyc;
    req = 4'b1001;
    push_run(c, 3);
    push_run(c + 9, 0);
    to_cyc(c + 10);
    req = 4'b0000;
    to_cyc(c + 18);
    chk("fair_idle_busy", 32'(busy), 32'd0);

    // Single request.
    c = cyc;
    req = 4'b0010;
    push_run(c, 1);
    to_cyc(c + 1);
    req = 4'b0000;
    chk("single_xout", 32'(x_out), 32'd1);
    chk("single_grant", 32'(grant), 32'b0010);
    chk("single_busy", 32'(busy), 32'd1);
    to_cyc(c + 8);
    chk("single_grant_off", 32'(grant), 32'd0);
    chk("single_busy_gap", 32'(busy), 32'd1);
    to_cyc(c + 9);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Reset during the fourth RUN cycle: run dropped, new strobe after release.
    c = cyc;
    req = 4'b0001;
    push_ev(c + 1, 1'b0, 0);
    push_run(c + 6, 0);
    to_cyc(c + 5);
    reset_b = 1'b0;
    to_cyc(c + 6);
    reset_b = 1'b1;
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_grant_id", 32'(grant_id), 32'd0);
    chk("mrst_x_out", 32'(x_out), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    to_cyc(c + 7);
    req = 4'b0000;
    chk("mrst_restart_xout", 32'(x_out), 32'd1);
    to_cyc(c + 15);
    chk("mrst_idle_busy", 32'(busy), 32'd0);

    // GAP=0 build with req=0011 held.
    c = cyc;
    req_g = 4'b0011;
    to_cyc(c + 1);
    chk("g0_xout1", 32'(x_out_g), 32'd1);
    chk("g0_grant1", 32'(grant_g), 32'b0001);
    to_cyc(c + 7);
    chk("g0_done0", 32'(done_g), 32'b0001);
    chk("g0_grant_run", 32'(grant_g), 32'b0001);
    to_cyc(c + 8);
    chk("g0_idle_busy", 32'(busy_g), 32'd0);
    chk("g0_idle_grant", 32'(grant_g), 32'd0);
    chk("g0_idle_xout", 32'(x_out_g), 32'd0);
    to_cyc(c + 9);
    req_g = 4'b0000;
    chk("g0_xout2", 32'(x_out_g), 32'd1);
    chk("g0_grant2", 32'(grant_g), 32'b0010);
    chk("g0_grant_id2", 32'(grant_id_g), 32'd1);
    to_cyc(c + 20);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
